// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, drives a 1-cycle synchronous instruction memory
// and hands {pc, instr} to decode over valid/ready. Optional perf counters: IFU_PERF_CNT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] perf_fetch_cnt,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_redir_cnt
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);
    localparam logic [XLEN-1:0] INSN_BYTES = XLEN'(32'd4);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e          state_q;
    state_e          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] resp_pc_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] redir_tgt;
    logic            run_en;
    logic            stall;
    logic            issue;
    logic            replay;

    // Run/halt FSM; fetch_en takes effect on issue in the same cycle it changes.
    always_comb begin
        state_d = state_q;
        run_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_en) begin
                    state_d = RUN;
                    run_en  = 1'b1;
                end
            end
            RUN: begin
                if (fetch_en) begin
                    run_en = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Address select: redirect beats replay-on-stall beats sequential fetch.
    always_comb begin
        redir_tgt = redirect_pc & ALIGN_MASK;
        stall     = resp_valid_q && !if_ready;
        imem_addr = pc_q;
        issue     = 1'b0;
        replay    = 1'b0;
        if (redirect_valid) begin
            imem_addr = redir_tgt;
            issue     = run_en;
        end else if (stall) begin
            imem_addr = resp_pc_q;
            replay    = 1'b1;
        end else if (run_en) begin
            issue = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response tracking: a replay holds everything so the memory re-reads the same word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_PC;
            resp_pc_q    <= RESET_PC;
            resp_valid_q <= 1'b0;
        end else if (issue) begin
            resp_pc_q    <= imem_addr;
            resp_valid_q <= 1'b1;
            pc_q         <= imem_addr + INSN_BYTES;
        end else if (!replay) begin
            resp_valid_q <= 1'b0;
            if (redirect_valid) begin
                pc_q <= imem_addr;
            end
        end
    end

    assign if_valid = resp_valid_q;
    assign if_pc    = resp_pc_q;
    assign if_instr = imem_rdata;

`ifdef IFU_PERF_CNT_EN
    logic [XLEN-1:0] fetch_cnt_q;
    logic [XLEN-1:0] stall_cnt_q;
    logic [XLEN-1:0] redir_cnt_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (resp_valid_q && if_ready) fetch_cnt_q <= fetch_cnt_q + XLEN'(32'd1);
            if (stall)                    stall_cnt_q <= stall_cnt_q + XLEN'(32'd1);
            if (redirect_valid)           redir_cnt_q <= redir_cnt_q + XLEN'(32'd1);
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_redir_cnt = redir_cnt_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
    assign perf_redir_cnt = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected accepted PCs are generated as a
// sequential stream restarted on reset/redirect; a monitor pops and checks each handshake.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_redir_cnt;

    instruction_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_redir_cnt (perf_redir_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    // Synchronous-read memory, one cycle of latency.
    always @(posedge clk) imem_rdata <= memfn(imem_addr);

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] gen_pc;
    int          m_fetch = 0;
    int          m_stall = 0;
    int          m_redir = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        exp_q.delete();
        gen_pc = pc;
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    // Drive one cycle's inputs at negedge; update the expected stream after the monitor ran.
    task automatic step(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        fetch_en       = fe;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if (rv) m_redir++;
        #3;
        if (rv) restart(rpc & 32'hFFFF_FFFC);
        refill();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        m_fetch = 0;
        m_stall = 0;
        m_redir = 0;
        #3;
        restart(RESET_PC);
        refill();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, RESET_PC);
        chk("rst_addr", imem_addr, RESET_PC);
    endtask

    // Release with fetch_en=1: issue in cycle 1, first valid in cycle 2.
    task automatic do_release();
        @(negedge clk);
        rst_n    = 1'b1;
        fetch_en = 1'b1;
        if_ready = 1'b1;
        #3;
        refill();
        chk("rel_c1_valid", 32'(if_valid), 32'd0);
        chk("rel_c1_addr", imem_addr, RESET_PC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rel_c2_valid", 32'(if_valid), 32'd1);
        chk("rel_c2_pc", if_pc, RESET_PC);
    endtask

    logic        prev_hold = 1'b0;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    logic [31:0] exp_pc;

    // Monitor: checks every handshake against the scoreboard and holds stable while stalled.
    always begin
        @(negedge clk);
        #2;
        if (rst_n) begin
            if (prev_hold) begin
                chk("hold_valid", 32'(if_valid), 32'd1);
                chk("hold_pc", if_pc, prev_pc);
                chk("hold_instr", if_instr, prev_instr);
            end
            if (if_valid && if_ready) begin
                m_fetch++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_unexpected: got pc %h expected no accept", if_pc);
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk("acc_pc", if_pc, exp_pc);
                    chk("acc_instr", if_instr, memfn(exp_pc));
                end
            end
            if (if_valid && !if_ready) m_stall++;
            prev_hold  = if_valid && !if_ready && !redirect_valid;
            prev_pc    = if_pc;
            prev_instr = if_instr;
        end else begin
            prev_hold = 1'b0;
        end
    end

    logic [31:0] w_pc;
    logic [31:0] halt_addr;
    logic        seen;

    initial begin
        restart(RESET_PC);
        refill();
        #1 rst_n = 1'b0;
        @(negedge clk);
        #3;
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, RESET_PC);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_perf_redir", perf_redir_cnt, 32'd0);
        do_release();

        // Sequential stream then a 3-cycle stall on pc 8.
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("seq_pc4", if_pc, 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            chk("stall_addr", imem_addr, 32'd8);
            chk("stall_pc", if_pc, 32'd8);
            chk("stall_instr", if_instr, memfn(32'd8));
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("stall_release_pc", if_pc, 32'd8);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("resume_pc", if_pc, 32'd12);

        // Redirect while stalled: held word is dropped, target appears next cycle.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h103);
        chk("redir_addr", imem_addr, 32'h100);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir_valid", 32'(if_valid), 32'd1);
        chk("redir_pc", if_pc, 32'h100);

        // Halt with a held word: accepted, then idle with a constant address.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        w_pc = if_pc;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("halt_held_valid", 32'(if_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        halt_addr = imem_addr;
        chk("halt_addr", halt_addr, w_pc + 32'd4);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("halt_idle_valid", 32'(if_valid), 32'd0);
            chk("halt_addr_const", imem_addr, halt_addr);
        end
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("reenable_pc", if_pc, w_pc + 32'd4);

        // Wrap at the top of the address space.
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc_top", if_pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        chk("wrap_pc_zero", if_pc, 32'h0);

        // Randomized traffic with one mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset();
                do_release();
            end
            step(($urandom % 8) != 0, ($urandom % 4) != 0, ($urandom % 10) == 0, $urandom);
        end

        // Drain: a valid must appear within a bounded number of cycles.
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (if_valid) seen = 1'b1;
        end
        chk("drain_valid_seen", 32'(seen), 32'd1);
        step(1'b0, 1'b1, 1'b0, 32'h0);

        @(negedge clk);
        #1;
`ifdef IFU_PERF_CNT_EN
        chk("perf_fetch", perf_fetch_cnt, 32'(m_fetch));
        chk("perf_stall", perf_stall_cnt, 32'(m_stall));
        chk("perf_redir", perf_redir_cnt, 32'(m_redir));
`else
        chk("perf_fetch", perf_fetch_cnt, 32'd0);
        chk("perf_stall", perf_stall_cnt, 32'd0);
        chk("perf_redir", perf_redir_cnt, 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
